// File: rtl/nios2_debug_ocimem_sequencer_pkg.sv
// Shared state encoding and jdo field positions for the debug OCI memory sequencer.
package nios2_debug_ocimem_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_ocimem_timeout.sv
// Consecutive-stall counter; expired flags the TIMEOUT-th stalled cycle so the
// owner can abort on that same clock edge.
module nios2_debug_ocimem_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    assign expired = enable && (count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/nios2_debug_ocimem_sequencer.sv
// Turns debug-slave action strobes into single-beat reads/writes on the debug
// memory port, with auto-increment addressing and a bounded waitrequest stall.
module nios2_debug_ocimem_sequencer
    import nios2_debug_ocimem_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              start_rd;
    logic              start_wr;
    logic              dropped;
    logic              tmo_expired;
    logic              unused_jdo;

    assign busy        = (state != ST_IDLE);
    assign mem_address = addr;
    assign unused_jdo  = ^{jdo[37:36], jdo[2:0]};

    nios2_debug_ocimem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!busy),
        .enable  (busy && mem_waitrequest),
        .expired (tmo_expired)
    );

    // Strobe arbitration: a > no_action_a > b; everything else is dropped.
    always_comb begin
        start_rd = 1'b0;
        start_wr = 1'b0;
        dropped  = 1'b0;
        if (busy) begin
            dropped = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        end else if (take_action_ocimem_a) begin
            start_rd = jdo[JDO_RD_BIT];
            dropped  = take_no_action_ocimem_a | take_action_ocimem_b;
        end else if (take_no_action_ocimem_a) begin
            start_rd = 1'b1;
            dropped  = take_action_ocimem_b;
        end else begin
            start_wr = take_action_ocimem_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            MonDReg       <= 32'd0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= 32'd0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            // A drop in the same cycle as an accepted load still flags the error.
            if (!busy && take_action_ocimem_a)
                monitor_error <= dropped;
            else if (dropped)
                monitor_error <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (take_action_ocimem_a)
                        addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (start_rd) begin
                        state         <= ST_READ;
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                    end
                    if (start_wr) begin
                        state         <= ST_WRITE;
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                        mem_writedata <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    end
                end
                default: begin
                    if (!mem_waitrequest) begin
                        if (state == ST_READ)
                            MonDReg <= mem_readdata;
                        addr          <= addr + ADDR_W'(1);
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tmo_expired) begin
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_debug_ocimem_sequencer.sv
// Directed plus randomized checks of the debug OCI memory sequencer against a
// transaction-level model (expected address, data, error and request length).
module tb_nios2_debug_ocimem_sequencer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [37:0] jdo;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: what the debugger should observe after each command.
    logic [7:0]  m_addr;
    logic [31:0] m_mondreg;
    logic        m_err;

    logic [2:0]  rs;
    logic [37:0] rj;
    int          rw;
    bit          rb;

    nios2_debug_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_waitrequest         (mem_waitrequest),
        .mem_readdata            (mem_readdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] j_a(input logic rd, input logic [7:0] ad);
        logic [37:0] j;
        j = {6'($urandom), $urandom};
        j[35] = rd;
        j[24:17] = ad;
        return j;
    endfunction

    function automatic logic [37:0] j_b(input logic [31:0] d);
        logic [37:0] j;
        j = {6'($urandom), $urandom};
        j[34:3] = d;
        return j;
    endfunction

    // Issue one strobe set at a negedge with the DUT idle; slave stalls `waits`
    // request cycles then answers. busy_b injects a b strobe in request cycle 2.
    task automatic run_cmd(input logic a, input logic na, input logic b, input logic [37:0] j,
                           input int waits, input logic [31:0] rdata, input bit busy_b);
        int          kind;
        int          exp_cycles;
        int          nreq;
        bit          done;
        logic [7:0]  req_addr;
        logic [31:0] wdata;
        wdata = j[34:3];
        kind  = 0;
        if (a) begin
            m_addr = j[24:17];
            m_err  = 1'b0;
            kind   = j[35] ? 1 : 0;
        end else if (na) begin
            kind = 1;
        end else if (b) begin
            kind      = 2;
            m_mondreg = wdata;
        end
        if (int'(a) + int'(na) + int'(b) > 1) m_err = 1'b1;
        req_addr   = m_addr;
        exp_cycles = 0;
        if (kind != 0) begin
            if (busy_b) m_err = 1'b1;
            if (waits < TMO) begin
                exp_cycles = waits + 1;
                m_addr     = m_addr + 8'd1;
                if (kind == 1) m_mondreg = rdata;
            end else begin
                exp_cycles = TMO;
                m_err      = 1'b1;
            end
        end

        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        jdo                     = j;
        mem_waitrequest         = 1'b1;
        mem_readdata            = $urandom;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo                     = {6'($urandom), $urandom};

        nreq = 0;
        done = 0;
        for (int c = 0; c < TMO + 4 && !done; c++) begin
            if (mem_read || mem_write) begin
                nreq++;
                check("req_kind", {mem_write, mem_read}, (kind == 2) ? 2'b10 : 2'b01);
                check("req_addr", mem_address, req_addr);
                if (kind == 2) check("req_wdata", mem_writedata, wdata);
                check("busy_ready", monitor_ready, 1'b0);
                mem_waitrequest = (nreq <= waits);
                mem_readdata    = (nreq <= waits) ? $urandom : rdata;
                if (busy_b && nreq == 2) take_action_ocimem_b = 1'b1;
                @(negedge clk);
                take_action_ocimem_b = 1'b0;
            end else begin
                done = 1;
            end
        end
        mem_waitrequest = 1'b0;
        check("req_cycles", nreq, exp_cycles);
        check("ready", monitor_ready, 1'b1);
        check("error", monitor_error, m_err);
        check("mondreg", MonDReg, m_mondreg);
        check("addr", mem_address, m_addr);
    endtask

    initial begin
        reset_n                 = 1'b0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo                     = '0;
        mem_waitrequest         = 1'b0;
        mem_readdata            = '0;
        m_addr                  = 8'd0;
        m_mondreg               = 32'd0;
        m_err                   = 1'b0;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_read", mem_read, 1'b0);
        check("rst_write", mem_write, 1'b0);
        check("rst_wdata", mem_writedata, 32'd0);
        check("rst_addr", mem_address, 8'd0);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_ready", monitor_ready, 1'b1);
        check("rst_error", monitor_error, 1'b0);

        // Load 0x10 and read, zero wait.
        run_cmd(1, 0, 0, j_a(1'b1, 8'h10), 0, 32'hDEADBEEF, 0);

        // Write burst at 0x11..0x13.
        run_cmd(0, 0, 1, j_b(32'h1), 0, 32'h0, 0);
        run_cmd(0, 0, 1, j_b(32'h2), 1, 32'h0, 0);
        run_cmd(0, 0, 1, j_b(32'h3), 0, 32'h0, 0);

        // Address wrap-around.
        run_cmd(1, 0, 0, j_a(1'b0, 8'hFF), 0, 32'h0, 0);
        run_cmd(0, 1, 0, j_a(1'b0, 8'h00), 0, 32'h0BADF00D, 0);

        // Collision plus busy strobe during a 5-cycle stall.
        run_cmd(1, 0, 1, j_a(1'b1, 8'h40), 5, 32'h12345678, 1);

        for (int i = 0; i < 40; i++) begin
            rs = 3'($urandom_range(1, 7));
            rw = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
            rb = (rw >= 2) && ($urandom_range(0, 3) == 0);
            rj = {6'($urandom), $urandom};
            run_cmd(rs[2], rs[1], rs[0], rj, rw, $urandom, rb);
        end

        // Timeout boundaries, then error cleared by a load.
        run_cmd(0, 1, 0, j_a(1'b0, 8'h00), TMO - 1, 32'hCAFE0001, 0);
        run_cmd(0, 1, 0, j_a(1'b0, 8'h00), TMO, 32'hCAFE0002, 0);
        run_cmd(1, 0, 0, j_a(1'b0, 8'h22), 0, 32'h0, 0);

        // Reset during a stalled write, with the error flag set by a busy drop.
        take_action_ocimem_b = 1'b1;
        jdo                  = j_b(32'hA5A5A5A5);
        mem_waitrequest      = 1'b1;
        @(negedge clk);
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("pre_rst_write", mem_write, 1'b1);
        check("pre_rst_error", monitor_error, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_write", mem_write, 1'b0);
        check("async_rst_ready", monitor_ready, 1'b1);
        @(negedge clk);
        reset_n         = 1'b1;
        mem_waitrequest = 1'b0;
        m_addr          = 8'd0;
        m_mondreg       = 32'd0;
        m_err           = 1'b0;
        @(negedge clk);
        check("post_rst_addr", mem_address, m_addr);
        check("post_rst_ready", monitor_ready, 1'b1);
        check("post_rst_error", monitor_error, m_err);
        check("post_rst_mondreg", MonDReg, m_mondreg);
        check("post_rst_write", mem_write, 1'b0);

        run_cmd(0, 1, 0, j_a(1'b0, 8'h00), 2, 32'h5555AAAA, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
